fc10_sched: RTL and testbench
=============================

# fc10_sched

Sequencer for the 256→10 binary fully-connected output stage. It accepts a 256-bit binarized feature vector and fetches the 10 per-class weight rows from a synchronous weight ROM. It streams the rows back-to-back into the XNOR/popcount datapath, collects the 10 popcount scores, and reports the winning class (argmax) with its score. It sits between the last hidden layer and the top-level classification output.

## Interface
- NUM_CLASSES, 10, number of weight rows / scores (IDX_W = 4 bits wide index)
- IN_BITS, 256, feature/weight row width
- SCORE_W, 10, popcount score width
- DRAIN_TIMEOUT, 15, max cycles waited in DRAIN before declaring error

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  start request; honoured only in IDLE
- i_feat  in  IN_BITS  feature vector; sampled on accepted start
- o_w_rd  out  1  weight ROM read enable
- o_w_addr  out  IDX_W  weight ROM row address
- i_w_data  in  IN_BITS  ROM read data, valid exactly 1 cycle after o_w_rd
- o_fc_valid  out  1  datapath input valid
- o_fc_data  out  IN_BITS  latched feature vector to datapath
- o_fc_weight  out  IN_BITS  weight row to datapath (= i_w_data)
- i_fc_valid  in  1  datapath result valid
- i_fc_result  in  SCORE_W  datapath popcount score
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse, result valid
- o_class  out  IDX_W  argmax class index
- o_score  out  SCORE_W  score of o_class
- o_err  out  1  set with o_done if fewer than NUM_CLASSES results arrived

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: when i_start=1, latch i_feat into the feature register. Clear issue counter, result counter, best score (0), best index (0) and o_err. Go to FETCH.
- FETCH: o_w_rd=1 and o_w_addr=issue counter, for counts 0..NUM_CLASSES-1 on consecutive cycles. After issuing address NUM_CLASSES-1, go to DRAIN.
- o_fc_valid is o_w_rd delayed one register stage. o_fc_weight passes i_w_data through. o_fc_data is the feature register, held constant until the next accepted start.
- Result collection, active in FETCH and DRAIN: each i_fc_valid increments the result counter. If i_fc_result > best score (strict), the block updates the best score and sets the best index to the result counter value. Ties therefore keep the lower index.
- DRAIN: leave for DONE when the result counter reaches NUM_CLASSES, including a final result arriving this cycle. Also leave for DONE with o_err=1 if DRAIN_TIMEOUT cycles elapse first.
- DONE: o_done=1 for one cycle; o_class/o_score show best index/score; go to IDLE.
- o_class, o_score and o_err hold their values until the next accepted start.
- i_start outside IDLE is ignored.
- i_fc_valid in IDLE or DONE is ignored.
- Results beyond NUM_CLASSES are ignored.
- Reset at any time returns the block to IDLE, as in the reset values below. Stale datapath results arriving afterward are ignored, because the block is in IDLE.

## Timing
- Reset values: o_w_rd=0, o_w_addr=0, o_fc_valid=0, o_fc_data=0, o_busy=0, o_done=0, o_class=0, o_score=0, o_err=0. o_fc_weight follows i_w_data.
- Cycle 0: i_start sampled high in IDLE.
- Cycles 1–10: FETCH, o_w_rd=1, addresses 0–9.
- Cycles 2–11: o_fc_valid=1 with rows 0–9.
- The datapath has a fixed 4-cycle latency, so results arrive on cycles 6–15.
- Cycle 16: DONE, o_done=1.
- Cycle 17: IDLE; earliest next accepted start is cycle 17.
- Start-to-done latency is 16 cycles; o_busy is high on cycles 1–16.
- The scheduler does not depend on the exact datapath latency. Any latency up to DRAIN_TIMEOUT cycles after the last issue is tolerated.

## Test plan
- Reset then idle: all outputs at reset values, with no o_w_rd or o_fc_valid activity for 20 cycles.
- Normal run, scores 3,250,17,…,9 (max at index 1): addresses 0–9 on cycles 1–10, o_fc_valid on cycles 2–11, o_done on cycle 16, o_class=1, o_score=250, o_err=0.
- Tie, scores with 200 at indices 4 and 7 (all others lower): o_class=4, o_score=200.
- Extra start pulses during FETCH/DRAIN plus a spurious i_fc_valid while IDLE: no effect on the sequence or result, and exactly one o_done.
- Datapath drops the 10th result: o_done with o_err=1 after DRAIN_TIMEOUT cycles in DRAIN, and o_class reflects the 9 results received.
- rst asserted on cycle 8 of a run: all outputs return to reset values immediately. Late results are ignored. A new start then yields the correct answer with o_done 16 cycles later.

Source files
------------

// File: rtl/fc10_sched.sv
// Sequencer for the binary fully-connected output stage: streams weight rows from ROM
// into the XNOR/popcount datapath, collects per-class scores and reports the argmax.
`timescale 1ns/1ps

module fc10_sched #(
  parameter int NUM_CLASSES   = 10,
  parameter int IN_BITS       = 256,
  parameter int SCORE_W       = 10,
  parameter int DRAIN_TIMEOUT = 15,
  parameter int IDX_W         = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [IN_BITS-1:0] i_feat,
  output logic               o_w_rd,
  output logic [IDX_W-1:0]   o_w_addr,
  input  logic [IN_BITS-1:0] i_w_data,
  output logic               o_fc_valid,
  output logic [IN_BITS-1:0] o_fc_data,
  output logic [IN_BITS-1:0] o_fc_weight,
  input  logic               i_fc_valid,
  input  logic [SCORE_W-1:0] i_fc_result,
  output logic               o_busy,
  output logic               o_done,
  output logic [IDX_W-1:0]   o_class,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_err
);

  // state | meaning
  // IDLE  | waiting for i_start; results ignored
  // FETCH | one ROM read per cycle, rows 0..NUM_CLASSES-1
  // DRAIN | all rows issued; waiting for remaining results or timeout
  // DONE  | one-cycle o_done pulse with latched argmax
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int CNT_W = $clog2(NUM_CLASSES + 1);
  localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_ADDR   = IDX_W'(NUM_CLASSES - 1);
  localparam logic [CNT_W-1:0] ALL_RESULTS = CNT_W'(NUM_CLASSES);
  localparam logic [TMR_W-1:0] TMR_LOAD    = TMR_W'(DRAIN_TIMEOUT);

  state_t               state_q, state_d;
  logic [IN_BITS-1:0]   feat_q, feat_d;
  logic [IDX_W-1:0]     issue_q, issue_d;
  logic [CNT_W-1:0]     res_cnt_q, res_cnt_d;
  logic [SCORE_W-1:0]   best_score_q, best_score_d;
  logic [IDX_W-1:0]     best_idx_q, best_idx_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [IDX_W-1:0]     class_q, class_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 err_q, err_d;
  logic                 fc_valid_q;
  logic                 w_rd;
  logic                 collect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      feat_q       <= '0;
      issue_q      <= '0;
      res_cnt_q    <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      tmr_q        <= '0;
      class_q      <= '0;
      score_q      <= '0;
      err_q        <= 1'b0;
      fc_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      feat_q       <= feat_d;
      issue_q      <= issue_d;
      res_cnt_q    <= res_cnt_d;
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
      tmr_q        <= tmr_d;
      class_q      <= class_d;
      score_q      <= score_d;
      err_q        <= err_d;
      fc_valid_q   <= w_rd;
    end
  end

  always_comb begin
    state_d      = state_q;
    feat_d       = feat_q;
    issue_d      = issue_q;
    res_cnt_d    = res_cnt_q;
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    tmr_d        = tmr_q;
    class_d      = class_q;
    score_d      = score_q;
    err_d        = err_q;
    w_rd         = 1'b0;

    // Strict compare keeps the lower index on ties; surplus results are dropped.
    collect = ((state_q == ST_FETCH) || (state_q == ST_DRAIN)) &&
              i_fc_valid && (res_cnt_q < ALL_RESULTS);
    if (collect) begin
      res_cnt_d = res_cnt_q + CNT_W'(1);
      if (i_fc_result > best_score_q) begin
        best_score_d = i_fc_result;
        best_idx_d   = IDX_W'(res_cnt_q);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          feat_d       = i_feat;
          issue_d      = '0;
          res_cnt_d    = '0;
          best_score_d = '0;
          best_idx_d   = '0;
          class_d      = '0;
          score_d      = '0;
          err_d        = 1'b0;
          state_d      = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_rd    = 1'b1;
        issue_d = issue_q + IDX_W'(1);
        if (issue_q == LAST_ADDR) begin
          tmr_d   = TMR_LOAD;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Use the _d view so a final result arriving this cycle is captured.
        if (res_cnt_d == ALL_RESULTS) begin
          class_d = best_idx_d;
          score_d = best_score_d;
          state_d = ST_DONE;
        end else if (tmr_q <= TMR_W'(1)) begin
          class_d = best_idx_d;
          score_d = best_score_d;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_w_rd      = w_rd;
  assign o_w_addr    = w_rd ? issue_q : '0;
  assign o_fc_valid  = fc_valid_q;
  assign o_fc_data   = feat_q;
  assign o_fc_weight = i_w_data;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_class     = class_q;
  assign o_score     = score_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_fc10_sched.sv
// Self-checking bench for fc10_sched: ROM and fixed-latency datapath models plus an
// argmax reference computed directly from the per-row scores.
`timescale 1ns/1ps

module tb_fc10_sched;
  localparam int NUM = 10;
  localparam int IW  = 256;
  localparam int SW  = 10;
  localparam int TO  = 15;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [IW-1:0] i_feat = '0;
  logic [IW-1:0] i_w_data = '0;
  logic          i_fc_valid = 1'b0;
  logic [SW-1:0] i_fc_result = '0;
  logic          o_w_rd, o_fc_valid, o_busy, o_done, o_err;
  logic [3:0]    o_w_addr, o_class;
  logic [IW-1:0] o_fc_data, o_fc_weight;
  logic [SW-1:0] o_score;

  fc10_sched dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_feat(i_feat),
    .o_w_rd(o_w_rd), .o_w_addr(o_w_addr), .i_w_data(i_w_data),
    .o_fc_valid(o_fc_valid), .o_fc_data(o_fc_data), .o_fc_weight(o_fc_weight),
    .i_fc_valid(i_fc_valid), .i_fc_result(i_fc_result),
    .o_busy(o_busy), .o_done(o_done), .o_class(o_class), .o_score(o_score), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [IW-1:0] rom [NUM];
  int scores [NUM];
  int done_cyc, n_done, r_cls, r_scr, final_cls, seq_bad, data_bad, rst_bad;
  logic r_err;
  int exp_cls, exp_scr;

  function automatic logic [IW-1:0] rand_vec();
    logic [IW-1:0] v;
    for (int i = 0; i < IW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Argmax over the first n scores; strictly-greater update from a zero baseline.
  task automatic ref_argmax(input int n, output int idx, output int best);
    best = 0;
    idx  = 0;
    for (int k = 0; k < n; k++) begin
      if (scores[k] > best) begin
        best = scores[k];
        idx  = k;
      end
    end
  endtask

  // Cycle 0 is the cycle in which i_start is sampled high in IDLE.
  task automatic run_job(input bit drop, input bit noise, input int rst_at, input int tail);
    logic [IW-1:0] feat;
    logic          pv [80];
    int            ps [80];
    logic          rd_prev;
    logic [3:0]    addr_prev;
    int            exp_done, idx;
    bit            active, exp_rd, exp_fv, exp_busy;
    for (int k = 0; k < NUM; k++) rom[k] = rand_vec();
    for (int k = 0; k < 80; k++) begin pv[k] = 1'b0; ps[k] = 0; end
    feat = rand_vec();
    done_cyc = -1; n_done = 0; r_cls = -1; r_scr = -1; r_err = 1'bx;
    final_cls = -1; seq_bad = 0; data_bad = 0; rst_bad = 0;
    addr_prev = '0;
    exp_done = drop ? (NUM + 1 + TO) : (NUM + LAT + 2);
    if (noise) begin
      @(posedge clk); #1;
      i_start = 1'b0; i_fc_valid = 1'b1; i_fc_result = '1;
      #1;
    end
    @(posedge clk); #1;
    i_start = 1'b1; i_feat = feat; i_fc_valid = 1'b0; i_w_data = rand_vec();
    rd_prev = 1'b0;
    #1;
    if (o_busy !== 1'b0) seq_bad++;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      i_start = noise && (c == 3 || c == 9 || c == 14);
      i_feat = noise ? rand_vec() : feat;
      i_w_data = (rd_prev === 1'b1 && addr_prev < NUM) ? rom[addr_prev] : rand_vec();
      i_fc_valid = pv[c];
      i_fc_result = SW'(ps[c]);
      if (noise && done_cyc >= 0 && c == done_cyc + 1) begin
        i_fc_valid = 1'b1; i_fc_result = '1;
      end
      #1;
      active   = (rst_at == 0) || (c <= rst_at);
      exp_rd   = active && (c <= NUM);
      exp_fv   = active && (c >= 2) && (c <= NUM + 1);
      exp_busy = active && (c <= exp_done);
      if (o_w_rd !== exp_rd || (exp_rd && o_w_addr !== 4'(c - 1))) seq_bad++;
      if (o_fc_valid !== exp_fv || o_busy !== exp_busy) seq_bad++;
      rd_prev = o_w_rd; addr_prev = o_w_addr;
      if (exp_fv && o_fc_valid === 1'b1) begin
        idx = c - 2;
        if (o_fc_weight !== rom[idx] || o_fc_data !== feat) data_bad++;
        if (!(drop && idx == NUM - 1)) begin
          pv[c + LAT] = 1'b1;
          ps[c + LAT] = scores[idx];
        end
      end
      if (o_done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = c; r_cls = int'(o_class); r_scr = int'(o_score); r_err = o_err;
        end
      end
      final_cls = int'(o_class);
      if (rst_at != 0 && c == rst_at) begin
        #1 rst = 1'b1;
        #1;
        if (o_w_rd !== 1'b0 || o_w_addr !== 4'd0 || o_fc_valid !== 1'b0 || o_fc_data !== '0 ||
            o_busy !== 1'b0 || o_done !== 1'b0 || o_class !== 4'd0 || o_score !== '0 || o_err !== 1'b0)
          rst_bad++;
      end
      if (rst_at != 0 && c > rst_at &&
          (o_busy !== 1'b0 || o_done !== 1'b0 || o_class !== 4'd0 || o_score !== '0)) rst_bad++;
      if (rst_at != 0 && c == rst_at + 12) break;
      if (rst_at == 0 && done_cyc >= 0 && c == done_cyc + tail) break;
    end
    i_start = 1'b0; i_fc_valid = 1'b0;
  endtask

  task automatic test_reset();
    int act;
    rst = 1'b1;
    i_w_data = rand_vec();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_total++; if (o_w_rd !== 1'b0) $display("FAIL reset_w_rd got %0b want 0", o_w_rd); else n_pass++;
    n_total++; if (o_w_addr !== 4'd0) $display("FAIL reset_w_addr got %0d want 0", o_w_addr); else n_pass++;
    n_total++; if (o_fc_valid !== 1'b0) $display("FAIL reset_fc_valid got %0b want 0", o_fc_valid); else n_pass++;
    n_total++; if (o_fc_data !== '0) $display("FAIL reset_fc_data got %0h want 0", o_fc_data); else n_pass++;
    n_total++; if (o_fc_weight !== i_w_data) $display("FAIL reset_fc_weight got %0h want %0h", o_fc_weight, i_w_data); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", o_busy); else n_pass++;
    n_total++; if (o_done !== 1'b0) $display("FAIL reset_done got %0b want 0", o_done); else n_pass++;
    n_total++; if (o_class !== 4'd0) $display("FAIL reset_class got %0d want 0", o_class); else n_pass++;
    n_total++; if (o_score !== '0) $display("FAIL reset_score got %0d want 0", o_score); else n_pass++;
    n_total++; if (o_err !== 1'b0) $display("FAIL reset_err got %0b want 0", o_err); else n_pass++;
    act = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_w_rd !== 1'b0 || o_fc_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) act++;
    end
    n_total++; if (act != 0) $display("FAIL idle_activity got %0d active cycles want 0", act); else n_pass++;
  endtask

  task automatic test_normal();
    scores = '{3, 250, 17, 40, 88, 120, 5, 199, 63, 9};
    run_job(1'b0, 1'b0, 0, 2);
    ref_argmax(NUM, exp_cls, exp_scr);
    n_total++; if (seq_bad != 0) $display("FAIL normal_sequence got %0d bad cycles want 0", seq_bad); else n_pass++;
    n_total++; if (data_bad != 0) $display("FAIL normal_fc_data got %0d bad rows want 0", data_bad); else n_pass++;
    n_total++; if (done_cyc != 16) $display("FAIL normal_done_cycle got %0d want 16", done_cyc); else n_pass++;
    n_total++; if (n_done != 1) $display("FAIL normal_done_count got %0d want 1", n_done); else n_pass++;
    n_total++; if (r_cls != exp_cls) $display("FAIL normal_class got %0d want %0d", r_cls, exp_cls); else n_pass++;
    n_total++; if (r_scr != exp_scr) $display("FAIL normal_score got %0d want %0d", r_scr, exp_scr); else n_pass++;
    n_total++; if (r_err !== 1'b0) $display("FAIL normal_err got %0b want 0", r_err); else n_pass++;
    n_total++; if (final_cls != exp_cls) $display("FAIL normal_class_hold got %0d want %0d", final_cls, exp_cls); else n_pass++;
  endtask

  task automatic test_tie();
    scores = '{10, 150, 30, 199, 200, 0, 60, 200, 100, 50};
    run_job(1'b0, 1'b0, 0, 1);
    n_total++; if (r_cls != 4) $display("FAIL tie_class got %0d want 4", r_cls); else n_pass++;
    n_total++; if (r_scr != 200) $display("FAIL tie_score got %0d want 200", r_scr); else n_pass++;
  endtask

  task automatic test_noise();
    for (int k = 0; k < NUM; k++) scores[k] = int'($urandom_range(0, 256));
    run_job(1'b0, 1'b1, 0, 4);
    ref_argmax(NUM, exp_cls, exp_scr);
    n_total++; if (seq_bad != 0) $display("FAIL noise_sequence got %0d bad cycles want 0", seq_bad); else n_pass++;
    n_total++; if (data_bad != 0) $display("FAIL noise_fc_data got %0d bad rows want 0", data_bad); else n_pass++;
    n_total++; if (n_done != 1) $display("FAIL noise_done_count got %0d want 1", n_done); else n_pass++;
    n_total++; if (done_cyc != 16) $display("FAIL noise_done_cycle got %0d want 16", done_cyc); else n_pass++;
    n_total++; if (r_cls != exp_cls) $display("FAIL noise_class got %0d want %0d", r_cls, exp_cls); else n_pass++;
    n_total++; if (r_scr != exp_scr) $display("FAIL noise_score got %0d want %0d", r_scr, exp_scr); else n_pass++;
    n_total++; if (final_cls != exp_cls) $display("FAIL noise_class_hold got %0d want %0d", final_cls, exp_cls); else n_pass++;
  endtask

  task automatic test_drop();
    scores = '{20, 30, 100, 40, 50, 60, 70, 80, 90, 240};
    run_job(1'b1, 1'b0, 0, 2);
    ref_argmax(NUM - 1, exp_cls, exp_scr);
    n_total++; if (seq_bad != 0) $display("FAIL drop_sequence got %0d bad cycles want 0", seq_bad); else n_pass++;
    n_total++; if (done_cyc != NUM + 1 + TO) $display("FAIL drop_done_cycle got %0d want %0d", done_cyc, NUM + 1 + TO); else n_pass++;
    n_total++; if (r_err !== 1'b1) $display("FAIL drop_err got %0b want 1", r_err); else n_pass++;
    n_total++; if (r_cls != exp_cls) $display("FAIL drop_class got %0d want %0d", r_cls, exp_cls); else n_pass++;
    n_total++; if (r_scr != exp_scr) $display("FAIL drop_score got %0d want %0d", r_scr, exp_scr); else n_pass++;
  endtask

  task automatic test_rst_mid();
    for (int k = 0; k < NUM; k++) scores[k] = int'($urandom_range(0, 256));
    run_job(1'b0, 1'b0, 8, 0);
    n_total++; if (rst_bad != 0) $display("FAIL rst_mid_outputs got %0d bad samples want 0", rst_bad); else n_pass++;
    n_total++; if (n_done != 0) $display("FAIL rst_mid_done_count got %0d want 0", n_done); else n_pass++;
    for (int k = 0; k < NUM; k++) scores[k] = int'($urandom_range(0, 256));
    run_job(1'b0, 1'b0, 0, 1);
    ref_argmax(NUM, exp_cls, exp_scr);
    n_total++; if (seq_bad != 0) $display("FAIL rst_rerun_sequence got %0d bad cycles want 0", seq_bad); else n_pass++;
    n_total++; if (done_cyc != 16) $display("FAIL rst_rerun_done_cycle got %0d want 16", done_cyc); else n_pass++;
    n_total++; if (r_cls != exp_cls) $display("FAIL rst_rerun_class got %0d want %0d", r_cls, exp_cls); else n_pass++;
    n_total++; if (r_scr != exp_scr) $display("FAIL rst_rerun_score got %0d want %0d", r_scr, exp_scr); else n_pass++;
  endtask

  // Back-to-back jobs: each next start lands on the first IDLE cycle after DONE.
  task automatic test_back_to_back();
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NUM; k++)
        scores[k] = (r % 2 == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 256));
      run_job(1'b0, 1'b0, 0, 0);
      ref_argmax(NUM, exp_cls, exp_scr);
      n_total++; if (seq_bad != 0 || data_bad != 0) $display("FAIL b2b%0d_sequence got %0d/%0d bad want 0/0", r, seq_bad, data_bad); else n_pass++;
      n_total++; if (done_cyc != 16) $display("FAIL b2b%0d_done_cycle got %0d want 16", r, done_cyc); else n_pass++;
      n_total++; if (r_cls != exp_cls || r_scr != exp_scr) $display("FAIL b2b%0d_result got %0d/%0d want %0d/%0d", r, r_cls, r_scr, exp_cls, exp_scr); else n_pass++;
      n_total++; if (r_err !== 1'b0) $display("FAIL b2b%0d_err got %0b want 0", r, r_err); else n_pass++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_tie();
    test_noise();
    test_drop();
    test_rst_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
